// File: rtl/calc_pkg.sv
// Shared opcodes, FSM encoding and saturation limits for the calculator controller.
package calc_pkg;

  localparam logic [2:0] OP_ADD_AB = 3'b000;
  localparam logic [2:0] OP_SUB_AB = 3'b001;
  localparam logic [2:0] OP_ABS_B  = 3'b010;
  localparam logic [2:0] OP_ADD_BA = 3'b100;
  localparam logic [2:0] OP_SUB_BA = 3'b101;
  localparam logic [2:0] OP_ABS_A  = 3'b110;

  localparam logic [3:0] SAT_POS = 4'b0111;
  localparam logic [3:0] SAT_NEG = 4'b1000;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    EXEC = 2'd1,
    RESP = 2'd2
  } state_t;

endpackage

// File: rtl/calc_accum_ctrl.sv
// Accumulator controller: load 1 cycle / execute 2 cycles to rsp_valid; cmd_ready only in IDLE, result held until rsp_ready.
// Define CALC_SATURATE_EN to clamp overflowed results to 0111/1000 instead of writing the wrapped value.
module calc_accum_ctrl
  import calc_pkg::*;
#(
  parameter logic [3:0] RESET_ACC = 4'b0000
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       cmd_valid,
  output logic       cmd_ready,
  input  logic       cmd_load,
  input  logic [2:0] cmd_op,
  input  logic [3:0] cmd_data,
  output logic       rsp_valid,
  input  logic       rsp_ready,
  output logic [3:0] rsp_result,
  output logic       rsp_ovf,
  output logic [3:0] acc,
  output logic       sticky_ovf,
  input  logic       ovf_clr,
  output logic [2:0] dp_op,
  output logic [3:0] dp_a,
  output logic [3:0] dp_b,
  input  logic [3:0] dp_r,
  input  logic       dp_ovf
);

  state_t     state, state_nxt;
  logic [2:0] op_q;
  logic [3:0] opnd_q;
  logic [3:0] wr_val;
  logic       accept;

  assign cmd_ready = (state == IDLE);
  assign rsp_valid = (state == RESP);
  assign accept    = cmd_valid & cmd_ready;

  assign dp_op = op_q;
  assign dp_a  = acc;
  assign dp_b  = opnd_q;

  // A set sign bit after overflow means the true result was positive.
  always_comb begin
    wr_val = dp_r;
`ifdef CALC_SATURATE_EN
    if (dp_ovf) begin
      wr_val = dp_r[3] ? SAT_POS : SAT_NEG;
    end
`endif
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (cmd_valid) state_nxt = cmd_load ? RESP : EXEC;
      EXEC:    state_nxt = RESP;
      RESP:    if (rsp_ready) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      acc        <= RESET_ACC;
      op_q       <= 3'b000;
      opnd_q     <= 4'b0000;
      rsp_result <= 4'b0000;
      rsp_ovf    <= 1'b0;
      sticky_ovf <= 1'b0;
    end else begin
      if (accept) begin
        op_q   <= cmd_op;
        opnd_q <= cmd_data;
        if (cmd_load) begin
          acc        <= cmd_data;
          rsp_result <= cmd_data;
          rsp_ovf    <= 1'b0;
        end
      end
      if (state == EXEC) begin
        acc        <= wr_val;
        rsp_result <= wr_val;
        rsp_ovf    <= dp_ovf;
      end
      // A new overflow beats a simultaneous clear.
      if ((state == EXEC) && dp_ovf) begin
        sticky_ovf <= 1'b1;
      end else if (ovf_clr) begin
        sticky_ovf <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_calc_accum_ctrl.sv
// Bench for calc_accum_ctrl: behavioural datapath beside the DUT, directed plan then random commands vs a signed-arithmetic model.
module tb_calc_accum_ctrl;
  import calc_pkg::*;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       cmd_valid, cmd_ready, cmd_load;
  logic [2:0] cmd_op;
  logic [3:0] cmd_data;
  logic       rsp_valid, rsp_ready;
  logic [3:0] rsp_result;
  logic       rsp_ovf;
  logic [3:0] acc;
  logic       sticky_ovf, ovf_clr;
  logic [2:0] dp_op;
  logic [3:0] dp_a, dp_b, dp_r;
  logic       dp_ovf;

  int         checks = 0;
  int         errors = 0;
  logic [3:0] m_acc;
  logic       m_sticky;
  int         dp_v;

  calc_accum_ctrl #(.RESET_ACC(4'b0000)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .cmd_valid  (cmd_valid),
    .cmd_ready  (cmd_ready),
    .cmd_load   (cmd_load),
    .cmd_op     (cmd_op),
    .cmd_data   (cmd_data),
    .rsp_valid  (rsp_valid),
    .rsp_ready  (rsp_ready),
    .rsp_result (rsp_result),
    .rsp_ovf    (rsp_ovf),
    .acc        (acc),
    .sticky_ovf (sticky_ovf),
    .ovf_clr    (ovf_clr),
    .dp_op      (dp_op),
    .dp_a       (dp_a),
    .dp_b       (dp_b),
    .dp_r       (dp_r),
    .dp_ovf     (dp_ovf)
  );

  always #5 clk = ~clk;

  // True signed result of an opcode on two 4-bit two's complement values.
  function automatic int true_val(input logic [2:0] op, input logic [3:0] a, input logic [3:0] b);
    int sa, sb;
    sa = $signed(a);
    sb = $signed(b);
    case (op)
      3'b000, 3'b100: return sa + sb;
      3'b001:         return sa - sb;
      3'b101:         return sb - sa;
      3'b010, 3'b011: return (sb < 0) ? -sb : sb;
      default:        return (sa < 0) ? -sa : sa;
    endcase
  endfunction

  // External combinational datapath: wraps to 4 bits, flags out-of-range.
  always_comb begin
    dp_v   = true_val(dp_op, dp_a, dp_b);
    dp_r   = dp_v[3:0];
    dp_ovf = (dp_v > 7) || (dp_v < -8);
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic do_cmd(input logic ld, input logic [2:0] op, input logic [3:0] d,
                        input int hold, input logic clr);
    int         v, n;
    logic [3:0] e_r;
    logic       e_o;
    if (ld) begin
      e_r = d;
      e_o = 1'b0;
    end else begin
      v   = true_val(op, m_acc, d);
      e_o = (v > 7) || (v < -8);
      e_r = v[3:0];
`ifdef CALC_SATURATE_EN
      if (e_o) e_r = (v > 7) ? SAT_POS : SAT_NEG;
`endif
    end
    if (!ld && e_o) m_sticky = 1'b1;
    else if (clr)   m_sticky = 1'b0;

    cmd_valid = 1'b1; cmd_load = ld; cmd_op = op; cmd_data = d;
    rsp_ready = 1'($urandom_range(0, 1));
    chk("cmd_ready_idle", cmd_ready, 1);
    @(posedge clk); #1;
    // Source keeps valid asserted with junk; controller must ignore it until IDLE.
    cmd_load  = 1'($urandom_range(0, 1));
    cmd_op    = 3'($urandom_range(0, 7));
    cmd_data  = 4'($urandom_range(0, 15));
    ovf_clr   = clr;
    rsp_ready = ld ? 1'b0 : 1'($urandom_range(0, 1));
    n = 1;
    while (!rsp_valid && n < 8) begin
      if (n == 1) begin
        chk("exec_dp_op", dp_op, op);
        chk("exec_dp_b", dp_b, d);
        chk("exec_dp_a", dp_a, m_acc);
        chk("exec_cmd_ready", cmd_ready, 0);
      end
      @(posedge clk); #1;
      ovf_clr   = 1'b0;
      rsp_ready = 1'b0;
      n++;
    end
    chk("rsp_valid_seen", rsp_valid, 1);
    chk("latency", n, ld ? 1 : 2);
    chk("rsp_result", rsp_result, e_r);
    chk("rsp_ovf", rsp_ovf, e_o);
    chk("acc", acc, e_r);
    chk("dp_a_eq_acc", dp_a, e_r);
    m_acc = e_r;

    for (int i = 0; i < hold; i++) begin
      @(posedge clk); #1;
      ovf_clr = 1'b0;
      chk("hold_valid", rsp_valid, 1);
      chk("hold_result", rsp_result, e_r);
      chk("hold_ovf", rsp_ovf, e_o);
      chk("hold_cmd_ready", cmd_ready, 0);
    end
    rsp_ready = 1'b1;
    @(posedge clk); #1;
    rsp_ready = 1'b0; ovf_clr = 1'b0; cmd_valid = 1'b0;
    chk("rsp_drop", rsp_valid, 0);
    chk("ready_back", cmd_ready, 1);
    chk("sticky", sticky_ovf, m_sticky);
    chk("acc_after", acc, m_acc);
  endtask

  initial begin
    rst_n = 1'b0; cmd_valid = 1'b0; cmd_load = 1'b0; cmd_op = 3'b000; cmd_data = 4'b0000;
    rsp_ready = 1'b0; ovf_clr = 1'b0;
    m_acc = 4'b0000; m_sticky = 1'b0;
    #1;
    chk("rst_cmd_ready", cmd_ready, 1);
    chk("rst_rsp_valid", rsp_valid, 0);
    chk("rst_rsp_result", rsp_result, 0);
    chk("rst_rsp_ovf", rsp_ovf, 0);
    chk("rst_acc", acc, 0);
    chk("rst_sticky", sticky_ovf, 0);
    chk("rst_dp_op", dp_op, 0);
    chk("rst_dp_b", dp_b, 0);
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;

    // Directed plan
    do_cmd(1'b1, OP_ADD_AB, 4'b0101, 0, 1'b0);
    do_cmd(1'b0, OP_ADD_AB, 4'b0010, 0, 1'b0);
    do_cmd(1'b0, OP_ADD_AB, 4'b0001, 1, 1'b0);
    do_cmd(1'b1, OP_ADD_AB, 4'b0011, 0, 1'b0);
    do_cmd(1'b0, OP_SUB_BA, 4'b0001, 0, 1'b1);
    do_cmd(1'b0, OP_ABS_A,  4'b0000, 3, 1'b0);
    do_cmd(1'b1, OP_ADD_AB, 4'b1000, 0, 1'b0);
    do_cmd(1'b0, 3'b111,    4'b0101, 2, 1'b1);
    do_cmd(1'b0, OP_ABS_B,  4'b1101, 3, 1'b0);
    do_cmd(1'b0, 3'b011,    4'b1000, 0, 1'b0);

    // Reset in the middle of an execute: command is dropped silently.
    cmd_valid = 1'b1; cmd_load = 1'b0; cmd_op = OP_ADD_AB; cmd_data = 4'b0001;
    @(posedge clk); #1;
    cmd_valid = 1'b0;
    rst_n = 1'b0;
    #1;
    chk("midrst_acc", acc, 0);
    chk("midrst_rsp_valid", rsp_valid, 0);
    chk("midrst_rsp_result", rsp_result, 0);
    chk("midrst_sticky", sticky_ovf, 0);
    chk("midrst_dp_op", dp_op, 0);
    #1 rst_n = 1'b1;
    #1;
    chk("postrst_cmd_ready", cmd_ready, 1);
    for (int i = 0; i < 3; i++) begin
      @(posedge clk); #1;
      chk("postrst_no_rsp", rsp_valid, 0);
      chk("postrst_acc", acc, 0);
    end
    m_acc = 4'b0000; m_sticky = 1'b0;

    for (int k = 0; k < 250; k++) begin
      do_cmd(($urandom_range(0, 3) == 0), 3'($urandom_range(0, 7)), 4'($urandom_range(0, 15)),
             $urandom_range(0, 3), ($urandom_range(0, 4) == 0));
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
